shift_ex_stage: RTL and testbench
=================================

# shift_ex_stage

Two-stage pipelined execute wrapper for the combinational barrel shifter `shift`. Accepts decoded MIPS shift instructions (sll, srl, sra, sllv, srlv, srav) over a valid/ready handshake, decodes funct into the shifter controls, and drives registered operands into `shift`. It captures `sh` into an output register with backpressure and feeds write-back. Sits in the EX stage between the operand-read register and the write-back mux.

## Interface
Parameters:
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  rising-edge clock
- clrn  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream offers an instruction
- in_ready  out  1  block accepts this cycle
- in_funct  in  6  MIPS funct field
- in_rs  in  32  rs register value (variable shift amount = in_rs[4:0])
- in_rt  in  32  rt register value (data to shift)
- in_shamt  in  5  instruction shamt field
- in_rd  in  5  destination register
- sh_d  out  32  to shifter `d`
- sh_sa  out  5  to shifter `sa`
- sh_right  out  1  to shifter `right`
- sh_arith  out  1  to shifter `arith`
- sh_result  in  32  from shifter `sh`
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_data  out  32  shift result
- out_rd  out  5  destination register
- out_err  out  1  funct was not a shift opcode
- op_count  out  CNT_W  results delivered (out_valid & out_ready)

## Operation
- Decode (combinational at input, registered into stage 1):
  - 000000 sll: sa=shamt, right=0, arith=0
  - 000010 srl: sa=shamt, right=1, arith=0
  - 000011 sra: sa=shamt, right=1, arith=1
  - 000100 sllv: sa=rs[4:0], right=0, arith=0
  - 000110 srlv: sa=rs[4:0], right=1, arith=0
  - 000111 srav: sa=rs[4:0], right=1, arith=1
  - any other funct: err=1, sa=0, right=0, arith=0
- Stage 1 (S1) holds s1_valid, d=in_rt, sa, right, arith, rd, err. sh_* outputs come directly from S1 registers and are never driven from input ports.
- Stage 2 (S2) captures sh_result, forced to 0 when S1.err=1, plus rd and err, into out_data/out_rd/out_err. out_valid = s2_valid.
- Flow control:
  - s2_free = !s2_valid | out_ready
  - s1_adv = s1_valid & s2_free
  - in_ready = !s1_valid | s2_free, combinational and with no dependence on in_valid
  - S1 loads on in_valid & in_ready. S1 clears valid when s1_adv and no new load.
  - S2 loads on s1_adv. S2 clears valid on out_ready when nothing advances.
- Stage data registers hold their value while stalled. out_data, out_rd and out_err are stable whenever out_valid=1 and out_ready=0.
- op_count increments on out_valid & out_ready and wraps from 2^CNT_W-1 to 0.
- Illegal funct still flows through the pipeline and is delivered with out_err=1, out_data=0. It counts in op_count.
- in_rd=0 is passed through unchanged; write suppression belongs to write-back.

## Timing
- Reset (clrn=0, async): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_rd=0, out_err=0, op_count=0, sh_d=0, sh_sa=0, sh_right=0, sh_arith=0. in_ready=1 immediately while in reset.
- Latency:
  - Accept at edge N puts the operation in S1 during cycle N+1.
  - The result is captured at edge N+1, with out_valid=1 in cycle N+2.
- Throughput: one op per cycle while out_ready=1. There are no bubbles for back-to-back ops.
- Full: S1 and S2 both valid with out_ready=0 gives in_ready=0. The cycle out_ready rises, in_ready=1, and S2←S1 and S1←input happen on the same edge.
- Simultaneous events:
  - Output handshake and S1 advance on the same edge: S2 is replaced and out_valid stays 1.
  - Input accept and S1 advance on the same edge: S1 is replaced.
- Reset mid-operation: all in-flight ops are discarded, no output handshake occurs, and op_count returns to 0.
- sa width: only 5 bits are used. in_rs[31:5] is ignored.

## Test plan
- Reset then single sra with rt=32'h0000_0004, shamt=2, out_ready=1 -> out_valid exactly 2 cycles after accept, out_data=32'h1, out_err=0, op_count=1.
- srav rt=32'h8000_0000, rs=32'hFFFF_FFE4 (sa=4) -> out_data=32'hF800_0000. srlv with the same operands -> 32'h0800_0000. sllv rt=1, rs=31 -> 32'h8000_0000.
- 8 back-to-back sll ops (rt=1, shamt=0..7) with out_ready=1 -> in_ready never drops, outputs 1,2,4,...,128 in order on consecutive cycles, op_count=8.
- Backpressure: 3 ops issued with out_ready=0 -> accepts 2, in_ready=0 on the 3rd, out_data held stable. Raising out_ready -> all 3 delivered in order with no loss or duplication.
- funct=6'b100000 (add) with rt=5 -> out_valid after 2 cycles, out_err=1, out_data=0, op_count increments.
- Pulse clrn low while 2 ops are in flight -> out_valid=0, op_count=0 and sh_* outputs=0 asynchronously. A subsequent srl rt=32'hF0, shamt=4 returns 32'hF.

Source files
------------

// File: rtl/shift_ex_stage.sv
// shift_ex_stage: two-stage EX wrapper around the combinational barrel shifter.
// S1 registers the decoded shift controls and drives the shifter. S2 captures
// the shifter result for write-back. Both stages use valid/ready backpressure.
module shift_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_funct,
    input  logic [31:0]      in_rs,
    input  logic [31:0]      in_rt,
    input  logic [4:0]       in_shamt,
    input  logic [4:0]       in_rd,
    output logic [31:0]      sh_d,
    output logic [4:0]       sh_sa,
    output logic             sh_right,
    output logic             sh_arith,
    input  logic [31:0]      sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [4:0]       out_rd,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count
);

    // Stage 1 state: the operation currently presented to the shifter
    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_dat_q, s1_dat_d;
    logic [4:0]  s1_sa_q, s1_sa_d;
    logic        s1_right_q, s1_right_d;
    logic        s1_arith_q, s1_arith_d;
    logic [4:0]  s1_rd_q, s1_rd_d;
    logic        s1_err_q, s1_err_d;

    // Stage 2 state: the result offered to write-back
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_data_q, s2_data_d;
    logic [4:0]  s2_rd_q, s2_rd_d;
    logic        s2_err_q, s2_err_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Decoded controls for the incoming instruction
    logic [4:0] dec_sa;
    logic       dec_right, dec_arith, dec_err;

    logic s2_free, s1_adv, s1_load;

    // Handshake: S2 can take new data when empty or draining this cycle
    always_comb begin
        s2_free  = !s2_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_free;
        in_ready = !s1_valid_q || s2_free;
        s1_load  = in_valid && in_ready;
    end

    // funct decode; only the low 5 bits of rs feed a variable shift
    always_comb begin
        dec_sa    = 5'd0;
        dec_right = 1'b0;
        dec_arith = 1'b0;
        dec_err   = 1'b0;
        unique case (in_funct)
            6'b000000: dec_sa = in_shamt;
            6'b000010: begin dec_sa = in_shamt; dec_right = 1'b1; end
            6'b000011: begin dec_sa = in_shamt; dec_right = 1'b1; dec_arith = 1'b1; end
            6'b000100: dec_sa = in_rs[4:0];
            6'b000110: begin dec_sa = in_rs[4:0]; dec_right = 1'b1; end
            6'b000111: begin dec_sa = in_rs[4:0]; dec_right = 1'b1; dec_arith = 1'b1; end
            default:   dec_err = 1'b1;
        endcase
    end

    // Stage 1 next state: load on accept, drain on advance, else hold
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_dat_d   = s1_dat_q;
        s1_sa_d    = s1_sa_q;
        s1_right_d = s1_right_q;
        s1_arith_d = s1_arith_q;
        s1_rd_d    = s1_rd_q;
        s1_err_d   = s1_err_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_dat_d   = in_rt;
            s1_sa_d    = dec_sa;
            s1_right_d = dec_right;
            s1_arith_d = dec_arith;
            s1_rd_d    = in_rd;
            s1_err_d   = dec_err;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2 next state: capture shifter output (zeroed for illegal funct)
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_rd_d    = s2_rd_q;
        s2_err_d   = s2_err_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_data_d  = s1_err_q ? 32'd0 : sh_result;
            s2_rd_d    = s1_rd_q;
            s2_err_d   = s1_err_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Delivered-result counter, wraps naturally
    always_comb begin
        cnt_d = cnt_q;
        if (s2_valid_q && out_ready) cnt_d = cnt_q + 1'b1;
    end

    // Pipeline registers with asynchronous clear
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_valid_q <= 1'b0;
            s1_dat_q   <= '0;
            s1_sa_q    <= '0;
            s1_right_q <= 1'b0;
            s1_arith_q <= 1'b0;
            s1_rd_q    <= '0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_rd_q    <= '0;
            s2_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_dat_q   <= s1_dat_d;
            s1_sa_q    <= s1_sa_d;
            s1_right_q <= s1_right_d;
            s1_arith_q <= s1_arith_d;
            s1_rd_q    <= s1_rd_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_rd_q    <= s2_rd_d;
            s2_err_q   <= s2_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign sh_d      = s1_dat_q;
    assign sh_sa     = s1_sa_q;
    assign sh_right  = s1_right_q;
    assign sh_arith  = s1_arith_q;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_rd    = s2_rd_q;
    assign out_err   = s2_err_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Directed bench for shift_ex_stage; a behavioural barrel shifter closes the loop.
module tb_shift_ex_stage;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_funct = '0;
    logic [31:0] in_rs = '0;
    logic [31:0] in_rt = '0;
    logic [4:0]  in_shamt = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] sh_d;
    logic [4:0]  sh_sa;
    logic        sh_right, sh_arith;
    logic [31:0] sh_result;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_err;
    logic [15:0] op_count;

    int tests = 0;
    int fails = 0;

    shift_ex_stage #(.CNT_W(16)) dut (
        .clk(clk), .clrn(clrn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt),
        .in_shamt(in_shamt), .in_rd(in_rd),
        .sh_d(sh_d), .sh_sa(sh_sa), .sh_right(sh_right), .sh_arith(sh_arith),
        .sh_result(sh_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_err(out_err),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Reference barrel shifter standing in for the external `shift` block
    always_comb begin
        if (!sh_right)     sh_result = sh_d << sh_sa;
        else if (sh_arith) sh_result = $unsigned($signed(sh_d) >>> sh_sa);
        else               sh_result = sh_d >> sh_sa;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] sa, input logic [4:0] rd);
        in_valid = 1'b1; in_funct = f; in_rs = rs; in_rt = rt; in_shamt = sa; in_rd = rd;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_sh_d", sh_d, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        step(); step();
        clrn = 1'b1;

        // Single sra 4>>>2
        step();
        drive(6'b000011, 32'd0, 32'h4, 5'd2, 5'd3);
        chk("sra_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("sra_s1_no_out", 32'(out_valid), 32'd0);
        chk("sra_sh_d", sh_d, 32'h4);
        chk("sra_sh_ctl", {24'd0, sh_sa, sh_right, sh_arith, 1'b0}, {24'd0, 5'd2, 1'b1, 1'b1, 1'b0});
        step();
        chk("sra_out_valid", 32'(out_valid), 32'd1);
        chk("sra_out_data", out_data, 32'h1);
        chk("sra_out_err", 32'(out_err), 32'd0);
        chk("sra_out_rd", 32'(out_rd), 32'd3);
        step();
        chk("sra_op_count", 32'(op_count), 32'd1);
        chk("sra_drained", 32'(out_valid), 32'd0);

        // Variable shifts, back to back; rs[31:5] must be ignored
        drive(6'b000111, 32'hFFFF_FFE4, 32'h8000_0000, 5'd0, 5'd1);
        step();
        drive(6'b000110, 32'hFFFF_FFE4, 32'h8000_0000, 5'd0, 5'd2);
        step();
        chk("srav_data", out_data, 32'hF800_0000);
        chk("srav_rd", 32'(out_rd), 32'd1);
        drive(6'b000100, 32'd31, 32'h1, 5'd0, 5'd0);
        step();
        in_valid = 1'b0;
        chk("srlv_data", out_data, 32'h0800_0000);
        step();
        chk("sllv_data", out_data, 32'h8000_0000);
        chk("sllv_rd0", 32'(out_rd), 32'd0);
        step();
        chk("var_op_count", 32'(op_count), 32'd4);

        // Eight back-to-back sll ops at full throughput
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(6'b000000, 32'd0, 32'h1, 5'(i), 5'(i));
            else in_valid = 1'b0;
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
            if (i >= 2) begin
                chk("b2b_valid", 32'(out_valid), 32'd1);
                chk("b2b_data", out_data, 32'h1 << (i - 2));
            end
            step();
        end
        chk("b2b_op_count", 32'(op_count), 32'd12);
        chk("b2b_drained", 32'(out_valid), 32'd0);

        // Backpressure: two accepted, third stalls until out_ready rises
        out_ready = 1'b0;
        drive(6'b000010, 32'd0, 32'h100, 5'd1, 5'd5);
        step();
        drive(6'b000010, 32'd0, 32'h100, 5'd2, 5'd6);
        chk("bp_accept2", 32'(in_ready), 32'd1);
        step();
        drive(6'b000010, 32'd0, 32'h100, 5'd3, 5'd7);
        chk("bp_full", 32'(in_ready), 32'd0);
        chk("bp_out1", out_data, 32'h80);
        step();
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_hold_data", out_data, 32'h80);
        chk("bp_hold_rd", 32'(out_rd), 32'd5);
        chk("bp_hold_cnt", 32'(op_count), 32'd12);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_out2_valid", 32'(out_valid), 32'd1);
        chk("bp_out2", out_data, 32'h40);
        chk("bp_out2_rd", 32'(out_rd), 32'd6);
        step();
        chk("bp_out3", out_data, 32'h20);
        chk("bp_out3_rd", 32'(out_rd), 32'd7);
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_op_count", 32'(op_count), 32'd15);

        // Illegal funct (add) flows through with err set and zero data
        drive(6'b100000, 32'd0, 32'h5, 5'd3, 5'd9);
        step();
        in_valid = 1'b0;
        chk("ill_s1_no_out", 32'(out_valid), 32'd0);
        chk("ill_sh_ctl", {25'd0, sh_sa, sh_right, sh_arith}, 32'd0);
        step();
        chk("ill_valid", 32'(out_valid), 32'd1);
        chk("ill_err", 32'(out_err), 32'd1);
        chk("ill_data", out_data, 32'd0);
        chk("ill_rd", 32'(out_rd), 32'd9);
        step();
        chk("ill_op_count", 32'(op_count), 32'd16);

        // Asynchronous reset with two ops in flight
        out_ready = 1'b0;
        drive(6'b000010, 32'd0, 32'hFF, 5'd1, 5'd1);
        step();
        drive(6'b000010, 32'd0, 32'hFF, 5'd2, 5'd2);
        step();
        in_valid = 1'b0;
        chk("mid_out_valid", 32'(out_valid), 32'd1);
        #2 clrn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cnt", 32'(op_count), 32'd0);
        chk("mid_rst_sh_d", sh_d, 32'd0);
        chk("mid_rst_sh_ctl", {25'd0, sh_sa, sh_right, sh_arith}, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        clrn = 1'b1;
        out_ready = 1'b1;
        step();
        drive(6'b000010, 32'd0, 32'hF0, 5'd4, 5'd2);
        step();
        in_valid = 1'b0;
        chk("post_s1_only", 32'(out_valid), 32'd0);
        step();
        chk("post_valid", 32'(out_valid), 32'd1);
        chk("post_data", out_data, 32'hF);
        step();
        chk("post_op_count", 32'(op_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net in case the sequence stalls
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
